// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial A-B-BIN with valid/ready intake and done pulse; SERIAL_SUB_SAT_EN enables unsigned saturation
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] t;
  logic br, d, br_n, last;
  always_comb begin
    d = sa[0] ^ sb[0] ^ br;
    br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    last = cnt == CW'(WIDTH - 1);
    t = {d, diff};
    start_ready = state == IDLE;
    busy = state != IDLE;
    done = state == DONE;
    state_n = state == IDLE ? (start_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      br <= 1'b0;
      cnt <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start_valid) begin
        sa <= a;
        sb <= b;
        br <= bin;
        cnt <= '0;
        diff <= '0;
        bout <= 1'b0;
      end else if (state == RUN) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        br <= br_n;
        cnt <= cnt + CW'(1);
`ifdef SERIAL_SUB_SAT_EN
        diff <= (last && br_n) ? '0 : t[WIDTH:1];
`else
        diff <= t[WIDTH:1];
`endif
        if (last) bout <= br_n;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table plus scoreboard checks for WIDTH=8 and WIDTH=1 builds
module tb_serial_subtractor;
  typedef struct {logic [7:0] a; logic [7:0] b; logic bin; logic [7:0] d; logic bo;} vec_t;
  typedef struct {logic [7:0] d; logic bo;} exp_t;
  logic clk = 0, rst = 1, sv = 0, bin = 0, sr, busy, done, bo;
  logic [7:0] a = 0, b = 0, diff;
  logic sv1 = 0, a1 = 0, b1 = 0, bin1 = 0, sr1, busy1, done1, d1, bo1;
  int checks = 0, errors = 0, cyc = 0, acc = 0, acc1 = 0;
  exp_t q[$];
  exp_t q1[$];
  vec_t vt[9];
  exp_t e, e1;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start_valid(sv), .start_ready(sr), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bo));
  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(sr1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(d1), .bout(bo1));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t mk(input logic [7:0] dv, input logic bv);
    exp_t r;
    r.d = dv;
    r.bo = bv;
`ifdef SERIAL_SUB_SAT_EN
    if (bv) r.d = '0;
`endif
    return r;
  endfunction
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && sv && sr) acc = cyc;
    if (!rst && sv1 && sr1) acc1 = cyc;
  end
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: got done=1 expected no done");
      end else begin
        e = q.pop_front();
        chk("diff8", diff, e.d);
        chk("bout8", bo, e.bo);
        chk("latency8", cyc - acc, 8);
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done1: got done=1 expected no done");
      end else begin
        e1 = q1.pop_front();
        chk("diff1", d1, e1.d[0]);
        chk("bout1", bo1, e1.bo);
        chk("latency1", cyc - acc1, 1);
      end
    end
  end
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       input logic push, input logic [7:0] ed, input logic eb);
    int n = 0;
    while (!sr && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!sr) begin
      checks++;
      errors++;
      $display("FAIL ready8_timeout: got start_ready=0 expected 1");
    end
    a = ia;
    b = ib;
    bin = ibin;
    sv = 1;
    if (push) q.push_back(mk(ed, eb));
    @(posedge clk);
    #1;
    sv = 0;
    a = 8'($urandom);
    b = 8'($urandom);
    bin = 1'($urandom);
  endtask
  task automatic issue1(input logic ia, input logic ib, input logic ibin);
    int n = 0;
    int r;
    while (!sr1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!sr1) begin
      checks++;
      errors++;
      $display("FAIL ready1_timeout: got start_ready=0 expected 1");
    end
    r = int'(ia) - int'(ib) - int'(ibin);
    a1 = ia;
    b1 = ib;
    bin1 = ibin;
    sv1 = 1;
    q1.push_back(mk({7'd0, r[0]}, r < 0));
    @(posedge clk);
    #1;
    sv1 = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", q.size() + q1.size());
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    vt[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[3] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};
    vt[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vt[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vt[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vt[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};
    vt[8] = '{8'hC3, 8'h41, 1'b1, 8'h81, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", sr, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bo, 0);
    rst = 0;
    for (int i = 0; i < 9; i++) issue(vt[i].a, vt[i].b, vt[i].bin, 1, vt[i].d, vt[i].bo);
    drain();
    issue(8'h30, 8'h10, 1'b0, 1, 8'h20, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("run_busy", busy, 1);
    chk("run_ready", sr, 0);
    a = 8'h11;
    b = 8'h22;
    sv = 1;
    @(posedge clk);
    #1;
    sv = 0;
    drain();
    repeat (4) @(posedge clk);
    #1;
    issue(8'h55, 8'h0F, 1'b0, 0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("mid_rst_ready", sr, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_bout", bo, 0);
    chk("mid_rst_done", done, 0);
    repeat (12) @(posedge clk);
    #1;
    issue(8'h09, 8'h04, 1'b0, 1, 8'h05, 1'b0);
    drain();
    for (int i = 0; i < 8; i++) issue1(1'(i >> 2), 1'(i >> 1), 1'(i));
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
